// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared types and constants for the sequential MIPS ALU (alu_seq).
//   alu_op_t : 3-bit operation code, encoded to match the ALU decoder output.
//   state_t  : control FSM states of alu_seq.
//   ALU_WIDTH/ALU_SHW : default operand width and shift-amount width.
//   is_shift_op() : true for the iterative (shift-class) operations.
// -----------------------------------------------------------------------------
package alu_pkg;

  localparam int ALU_WIDTH = 32;
  localparam int ALU_SHW   = 5;

  typedef enum logic [2:0] {
    AND = 3'b000,
    OR  = 3'b001,
    ADD = 3'b010,
    SLL = 3'b011,
    ZFR = 3'b100,
    LI  = 3'b101,
    SUB = 3'b110,
    SLT = 3'b111
  } alu_op_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  function automatic logic is_shift_op(input alu_op_t op);
    return (op == SLL) || (op == ZFR);
  endfunction

endpackage

// File: rtl/alu_seq_if.sv
// -----------------------------------------------------------------------------
// alu_seq_if
// Request/response bundle between the datapath and alu_seq.
//   start, alucontrol, a, b : request side, driven by the master (datapath).
//   busy, done, y, zero     : response side, driven by the slave (alu_seq).
// -----------------------------------------------------------------------------
interface alu_seq_if #(
  parameter int WIDTH = alu_pkg::ALU_WIDTH
);

  logic             start;
  logic [2:0]       alucontrol;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] y;
  logic             zero;

  modport master (
    output start, alucontrol, a, b,
    input  busy, done, y, zero
  );

  modport slave (
    input  start, alucontrol, a, b,
    output busy, done, y, zero
  );

endinterface

// File: rtl/alu_comb.sv
// -----------------------------------------------------------------------------
// alu_comb
// Purely combinational evaluation of the single-cycle operations.
//   op : operation code
//   a  : operand A
//   b  : operand B / immediate
//   y  : result. For the shift-class codes it returns a, which is the correct
//        result when the shift amount is zero; non-zero shifts are iterated by
//        the parent and never use this output.
// -----------------------------------------------------------------------------
module alu_comb
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  alu_op_t          op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y
);

  logic lt;

  assign lt = ($signed(a) < $signed(b));

  always_comb begin
    // NOTE: y gets a value on every path (default first) so no latch is inferred.
    y = a;
    case (op)
      AND:     y = a & b;
      OR:      y = a | b;
      ADD:     y = a + b;
      SUB:     y = a - b;
      SLT:     y = {{(WIDTH-1){1'b0}}, lt};
      LI:      y = b;
      SLL,
      ZFR:     y = a;
      default: y = a;
    endcase
  end

endmodule

// File: rtl/alu_seq.sv
// -----------------------------------------------------------------------------
// alu_seq
// Sequential ALU for the multicycle MIPS datapath. Single-cycle ops finish with
// latency 1; sll/zfr iterate one bit position per cycle.
//   clk   : rising-edge clock
//   reset : synchronous, active-high reset
//   bus   : alu_seq_if.slave (start/alucontrol/a/b in, busy/done/y/zero out)
// Operands are captured when start is accepted in IDLE; start is ignored while
// busy. done is a one-cycle pulse while in DONE; y/zero are registered and hold
// until the next done.
// -----------------------------------------------------------------------------
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH,
  parameter int SHW   = ALU_SHW
) (
  input  logic       clk,
  input  logic       reset,
  alu_seq_if.slave   bus
);

  state_t           state_q, state_d;
  alu_op_t          op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] mask_q, mask_d;
  logic [SHW-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic             zero_q, zero_d;

  alu_op_t          start_op;
  logic [SHW-1:0]   shamt;
  logic [WIDTH-1:0] comb_y;
  logic [WIDTH-1:0] acc_step;
  logic [WIDTH-1:0] mask_step;

  assign start_op  = alu_op_t'(bus.alucontrol);
  assign shamt     = bus.b[SHW-1:0];
  assign acc_step  = acc_q << 1;
  assign mask_step = mask_q << 1;

  alu_comb #(
    .WIDTH (WIDTH)
  ) u_comb (
    .op (start_op),
    .a  (bus.a),
    .b  (bus.b),
    .y  (comb_y)
  );

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    a_d     = a_q;
    acc_d   = acc_q;
    mask_d  = mask_q;
    cnt_d   = cnt_q;
    y_d     = y_q;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          op_d = start_op;
          a_d  = bus.a;
          if (is_shift_op(start_op) && (shamt != '0)) begin
            acc_d   = bus.a;
            mask_d  = '1;
            cnt_d   = shamt;
            state_d = SHIFT;
          end else begin
            y_d     = comb_y;
            state_d = DONE;
          end
        end
      end

      SHIFT: begin
        // Only the register belonging to the active op moves; the other is
        // left alone. cnt == 1 marks the last of shamt steps, so the result is
        // taken from the stepped value directly.
        cnt_d = cnt_q - 1'b1;
        if (op_q == SLL) begin
          acc_d = acc_step;
        end else begin
          mask_d = mask_step;
        end
        if (cnt_q == 1) begin
          y_d     = (op_q == SLL) ? acc_step : (a_q & mask_step);
          state_d = DONE;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // zero always tracks the value y will hold, including when y holds.
    zero_d = (y_d == '0);
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values, independent of statement order.
    if (reset) begin
      state_q <= IDLE;
      op_q    <= AND;
      a_q     <= '0;
      acc_q   <= '0;
      mask_q  <= '0;
      cnt_q   <= '0;
      y_q     <= '0;
      zero_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      a_q     <= a_d;
      acc_q   <= acc_d;
      mask_q  <= mask_d;
      cnt_q   <= cnt_d;
      y_q     <= y_d;
      zero_q  <= zero_d;
    end
  end

  assign bus.busy = (state_q != IDLE);
  assign bus.done = (state_q == DONE);
  assign bus.y    = y_q;
  assign bus.zero = zero_q;

endmodule

// File: tb/tb_alu_seq.sv
// -----------------------------------------------------------------------------
// tb_alu_seq
// Self-checking bench for alu_seq. Expected results come from a behavioural
// model of the opcode table; expected latency is 1 for single-cycle ops or
// zero shifts and shamt+1 for non-zero shifts. Outputs are sampled 1 time unit
// after the rising edge; inputs are driven at the same point.
// -----------------------------------------------------------------------------
module tb_alu_seq;

  logic clk = 1'b0;
  logic reset;

  alu_seq_if #(.WIDTH(32)) bus ();

  alu_seq #(
    .WIDTH (32),
    .SHW   (5)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Reference model: result straight from the opcode table.
  function automatic logic [31:0] model_y(input logic [2:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    int unsigned n;
    logic [31:0] r;
    n = b[4:0];
    r = '0;
    case (op)
      3'b000: r = a & b;
      3'b001: r = a | b;
      3'b010: r = a + b;
      3'b110: r = a - b;
      3'b111: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      3'b101: r = b;
      3'b011: r = a << n;
      3'b100: begin
        r = a;
        for (int i = 0; i < 32; i++) if (i < n) r[i] = 1'b0;
      end
      default: r = 'x;
    endcase
    return r;
  endfunction

  function automatic int model_lat(input logic [2:0] op, input logic [31:0] b);
    if ((op == 3'b011 || op == 3'b100) && b[4:0] != 0) return int'(b[4:0]) + 1;
    return 1;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one op, follow it to done (bounded), check result, latency, busy,
  // y hold while busy, and that no second done follows. With disturb set, the
  // inputs are scrambled and start is held high while the op is in flight.
  task automatic run_op(input logic [2:0] op, input logic [31:0] av, input logic [31:0] bv,
                        input bit disturb, input string tag);
    logic [31:0] ey;
    logic [31:0] prev_y;
    int          el;
    int          done_cyc;
    int          cyc;
    bit          busy_ok;
    bit          hold_ok;
    ey       = model_y(op, av, bv);
    el       = model_lat(op, bv);
    prev_y   = bus.y;
    done_cyc = 0;
    busy_ok  = 1'b1;
    hold_ok  = 1'b1;

    bus.start      = 1'b1;
    bus.alucontrol = op;
    bus.a          = av;
    bus.b          = bv;
    tick();
    bus.start = 1'b0;
    for (cyc = 1; cyc <= 40; cyc++) begin
      if (!bus.busy) busy_ok = 1'b0;
      if (bus.done) begin
        done_cyc = cyc;
        break;
      end
      if (bus.y !== prev_y) hold_ok = 1'b0;
      if (disturb) begin
        bus.start      = 1'b1;
        bus.alucontrol = 3'($urandom);
        bus.a          = $urandom;
        bus.b          = $urandom;
      end
      tick();
    end
    check({tag, " latency"}, done_cyc, el);
    check({tag, " y"}, bus.y, ey);
    check({tag, " zero"}, {31'd0, bus.zero}, {31'd0, ey == 32'd0});
    check({tag, " busy"}, {31'd0, busy_ok}, 32'd1);
    check({tag, " y hold"}, {31'd0, hold_ok}, 32'd1);
    tick();
    bus.start = 1'b0;
    check({tag, " single done"}, {31'd0, bus.done}, 32'd0);
    check({tag, " idle"}, {31'd0, bus.busy}, 32'd0);
    check({tag, " y after"}, bus.y, ey);
  endtask

  initial begin
    logic [31:0] ra, rb;
    logic [2:0]  rop;
    int          dones;

    reset          = 1'b1;
    bus.start      = 1'b0;
    bus.alucontrol = 3'b000;
    bus.a          = '0;
    bus.b          = '0;
    tick();
    tick();
    reset = 1'b0;
    tick();
    tick();
    tick();
    check("reset busy", {31'd0, bus.busy}, 32'd0);
    check("reset done", {31'd0, bus.done}, 32'd0);
    check("reset y", bus.y, 32'd0);
    check("reset zero", {31'd0, bus.zero}, 32'd1);

    // Directed single-cycle ops.
    run_op(3'b010, 32'd7, 32'd5, 1'b0, "add");
    run_op(3'b110, 32'd5, 32'd5, 1'b0, "sub");
    run_op(3'b111, 32'hFFFF_FFFF, 32'd1, 1'b0, "slt");
    run_op(3'b101, 32'hDEAD_0000, 32'h0000_1234, 1'b0, "li");
    run_op(3'b000, 32'hF0F0_1234, 32'h0FF0_FF00, 1'b0, "and");
    run_op(3'b001, 32'hF000_0001, 32'h0000_1230, 1'b0, "or");

    // Directed shifts, including the shamt boundaries 0 and 31.
    run_op(3'b011, 32'h0000_0003, 32'd4, 1'b0, "sll4");
    run_op(3'b011, 32'h1234_5678, 32'hFFFF_FFE0, 1'b0, "sll0");
    run_op(3'b011, 32'h0000_0001, 32'd31, 1'b0, "sll31");
    run_op(3'b100, 32'hFFFF_FFFF, 32'd8, 1'b1, "zfr8 disturbed");
    run_op(3'b100, 32'hFFFF_FFFF, 32'd31, 1'b0, "zfr31");

    // Reset during SHIFT cycle 3 of an sll by 10 abandons the op.
    run_op(3'b010, 32'd7, 32'd5, 1'b0, "add pre-abort");
    bus.start      = 1'b1;
    bus.alucontrol = 3'b011;
    bus.a          = 32'h0000_0005;
    bus.b          = 32'd10;
    tick();
    bus.start = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("abort busy", {31'd0, bus.busy}, 32'd0);
    check("abort done", {31'd0, bus.done}, 32'd0);
    check("abort y", bus.y, 32'd0);
    check("abort zero", {31'd0, bus.zero}, 32'd1);
    dones = 0;
    for (int i = 0; i < 15; i++) begin
      if (bus.done) dones++;
      tick();
    end
    check("abort no late done", dones, 0);

    // Back-to-back: start held high; accepted every other cycle.
    bus.start      = 1'b1;
    bus.alucontrol = 3'b010;
    for (int k = 0; k < 6; k++) begin
      ra    = $urandom;
      rb    = $urandom;
      bus.a = ra;
      bus.b = rb;
      tick();
      check("b2b done", {31'd0, bus.done}, 32'd1);
      check("b2b y", bus.y, ra + rb);
      bus.a = $urandom;
      bus.b = $urandom;
      tick();
      check("b2b gap", {31'd0, bus.done}, 32'd0);
    end
    bus.start = 1'b0;
    tick();

    // Randomized ops, with random in-flight disturbance.
    for (int k = 0; k < 40; k++) begin
      rop = 3'($urandom_range(0, 7));
      ra  = $urandom;
      rb  = $urandom;
      if (k % 4 == 0) ra = 32'd0;
      if (k % 5 == 1) rb = rb & 32'h0000_0003;
      run_op(rop, ra, rb, 1'($urandom_range(0, 1)), "random");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
